// File: rtl/hdlbc_dec_key_sched_pkg.sv
// hdlbc_pkg: shared HDLBC widths, key-step constants and key-schedule state encoding
package hdlbc_pkg;
  localparam int HDLBC_KEY_W = 64;
  localparam int HDLBC_RC_W = 5;
  localparam int HDLBC_ROT = 16;
  localparam int HDLBC_PBOX_MUL = 13;
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;
endpackage

// File: rtl/hdlbc_dec_key_sched_ks_step.sv
// hdlbc_ks_step: combinational forward key step rk = f(k, rc); ports k (key in), rc (round constant), rk (next key)
module hdlbc_ks_step
  import hdlbc_pkg::*;
(
  input  logic [0:HDLBC_KEY_W-1] k,
  input  logic [HDLBC_RC_W-1:0]  rc,
  output logic [0:HDLBC_KEY_W-1] rk
);
  localparam int H = HDLBC_KEY_W / 2;
  logic [0:HDLBC_KEY_W-1] p;
  logic [0:H-1] l;
  logic [0:H-1] r;
  for (genvar i = 0; i < HDLBC_KEY_W; i++) begin : g_pbox
    assign p[i] = k[(i * HDLBC_PBOX_MUL) % HDLBC_KEY_W];
  end
  always_comb begin
    l = ~({p[HDLBC_ROT:H-1], p[0:HDLBC_ROT-1]} & p[H:HDLBC_KEY_W-1]);
    r = l ^ p[H:HDLBC_KEY_W-1];
    rk = {l, r[0:H-HDLBC_RC_W-1], r[H-HDLBC_RC_W:H-1] ^ rc};
  end
endmodule

// File: rtl/hdlbc_dec_key_sched.sv
// hdlbc_dec_key_sched: expands key forward into a buffer, then streams round keys ROUNDS..1; ports start/key in, busy, rk/rk_idx/rk_valid/rk_ready stream, done pulse
module hdlbc_dec_key_sched
  import hdlbc_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [0:HDLBC_KEY_W-1] key,
  output logic                   busy,
  output logic [0:HDLBC_KEY_W-1] rk,
  output logic [HDLBC_RC_W-1:0]  rk_idx,
  output logic                   rk_valid,
  input  logic                   rk_ready,
  output logic                   done
);
  localparam int AW = ROUNDS > 1 ? $clog2(ROUNDS) : 1;
  localparam logic [HDLBC_RC_W-1:0] LAST = HDLBC_RC_W'(ROUNDS);
  localparam logic [HDLBC_RC_W-1:0] ONE = HDLBC_RC_W'(1);
  state_t state;
  state_t state_n;
  logic [HDLBC_RC_W-1:0] cnt;
  logic [0:HDLBC_KEY_W-1] kreg;
  logic [0:HDLBC_KEY_W-1] step;
  logic [0:HDLBC_KEY_W-1] rk_q;
  logic [0:HDLBC_KEY_W-1] mem [ROUNDS];
  logic done_q;
  logic hs;
  hdlbc_ks_step u_step (.k(kreg), .rc(cnt), .rk(step));
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (start ? EXPAND : IDLE) :
              state == EXPAND ? (cnt == LAST ? EMIT : EXPAND) :
              (hs && cnt == ONE ? IDLE : EMIT);
  always_comb begin
    busy = state != IDLE;
    rk_valid = state == EMIT;
    rk_idx = rk_valid ? cnt : '0;
    rk = rk_valid ? rk_q : '0;
    done = done_q;
    hs = rk_valid & rk_ready;
  end
  // cnt is the round being computed in EXPAND and the index being presented in EMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      kreg <= '0;
      rk_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= hs && cnt == ONE;
      if (state == IDLE && start) begin
        kreg <= key;
        cnt <= ONE;
      end
      if (state == EXPAND) begin
        kreg <= step;
        rk_q <= step;
        if (cnt != LAST) cnt <= cnt + ONE;
      end
      if (hs && cnt != ONE) begin
        cnt <= cnt - ONE;
        rk_q <= mem[AW'(cnt - 2)];
      end
    end
  end
  // mem[i-1] holds round key i
  always_ff @(posedge clk)
    if (state == EXPAND) mem[AW'(cnt - ONE)] <= step;
endmodule
